// File: rtl/lpffir_csa_acc.sv
// Carry-save tap-sum accumulator with bit-serial sum+carry resolution and a valid/ready result port.
// Optional output saturation: define LPFFIR_ACC_SAT_EN.
module lpffir_csa_acc #(
    parameter int W  = 16,
    parameter int AW = 20,
    parameter int OW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] out_data_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    localparam int CW = $clog2(AW + 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        s_q, c_q, r_q;
    logic                 cy_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] x;
    logic [AW-2:0]        maj;
    logic                 accept, res_done, sum_bit, cy_d;
    logic [OW-1:0]        res;

`ifdef LPFFIR_ACC_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    logic signed [AW-1:0] r_s;
`endif

    always_comb begin
        in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        accept      = in_valid_i && in_ready_o;
        res_done    = (cnt_q == CW'(AW));
        x           = AW'($signed(in_data_i));
        // Bit AW-1 of the majority would carry out of the word, so it is never formed.
        maj         = (s_q[AW-2:0] & c_q[AW-2:0]) | (s_q[AW-2:0] & x[AW-2:0]) |
                      (c_q[AW-2:0] & x[AW-2:0]);
        sum_bit     = s_q[0] ^ c_q[0] ^ cy_q;
        cy_d        = (s_q[0] & c_q[0]) | (s_q[0] & cy_q) | (c_q[0] & cy_q);
    end

    always_comb begin
        res = r_q[OW-1:0];
`ifdef LPFFIR_ACC_SAT_EN
        r_s = r_q;
        if (r_s > SAT_MAX)
            res = SAT_MAX[OW-1:0];
        else if (r_s < SAT_MIN)
            res = SAT_MIN[OW-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = in_last_i ? RESOLVE : ACCUM;
            ACCUM:   if (accept && in_last_i) state_d = RESOLVE;
            RESOLVE: if (res_done) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q        <= '0;
            c_q        <= '0;
            r_q        <= '0;
            cy_q       <= 1'b0;
            cnt_q      <= '0;
            out_data_o <= '0;
        end else if (accept) begin
            s_q <= s_q ^ c_q ^ x;
            c_q <= {maj, 1'b0};
        end else if (state_q == RESOLVE) begin
            if (!res_done) begin
                // LSB-first ripple: one full adder, result fills R from the top.
                r_q   <= {sum_bit, r_q[AW-1:1]};
                cy_q  <= cy_d;
                s_q   <= {1'b0, s_q[AW-1:1]};
                c_q   <= {1'b0, c_q[AW-1:1]};
                cnt_q <= cnt_q + CW'(1);
            end else begin
                out_data_o <= res;
            end
        end else if (state_q == DONE && out_ready_i) begin
            s_q   <= '0;
            c_q   <= '0;
            r_q   <= '0;
            cy_q  <= 1'b0;
            cnt_q <= '0;
        end
    end

endmodule
